// File: rtl/alu_issue_if.sv
// Request/response channels between decode, the ALU issue controller and writeback.
// slave is the controller side, master is the decode/writeback side.
interface alu_issue_if #(parameter int WIDTH = 64);
  logic             ReqValid;
  logic             ReqReady;
  logic [1:0]       ALUOp;
  logic [2:0]       Funct3;
  logic             Funct7b5;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             RespValid;
  logic             RespReady;
  logic [WIDTH-1:0] RespData;
  logic             RespZero;
  logic             RespOverflow;
  logic             BranchTaken;
  logic             IllegalOp;

  modport slave (
    input  ReqValid, ALUOp, Funct3, Funct7b5, OpA, OpB, RespReady,
    output ReqReady, RespValid, RespData, RespZero, RespOverflow, BranchTaken, IllegalOp
  );

  modport master (
    output ReqValid, ALUOp, Funct3, Funct7b5, OpA, OpB, RespReady,
    input  ReqReady, RespValid, RespData, RespZero, RespOverflow, BranchTaken, IllegalOp
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded op to the combinational ALU, samples it a cycle later and
// returns result, flags and branch decision on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       io,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluOperation,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluZero,
  input  logic             AluOverflow
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_t;

  state_t     state_q, state_d;
  logic [3:0] dec_op;
  br_t        dec_br, br_q;
  logic       dec_ill, ill_q, ovf_en_q;
  logic       req_fire, resp_fire, taken;

  // Decode; illegal encodings collapse to a plain ADD with no branch.
  always_comb begin
    dec_op  = OP_ADD;
    dec_br  = BR_NONE;
    dec_ill = 1'b0;
    unique case (io.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        unique case (io.Funct3)
          3'b000:  begin dec_op = OP_SUB; dec_br = BR_EQ; end
          3'b001:  begin dec_op = OP_SUB; dec_br = BR_NE; end
          3'b100:  begin dec_op = OP_SLT; dec_br = BR_LT; end
          3'b101:  begin dec_op = OP_SLT; dec_br = BR_GE; end
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        // ALUOp[0] set means I-type, where bit 30 is immediate, not an opcode bit.
        unique case (io.Funct3)
          3'b000:  dec_op = (io.Funct7b5 && !io.ALUOp[0]) ? OP_SUB : OP_ADD;
          3'b111:  begin dec_op = OP_AND; dec_ill = io.Funct7b5 && !io.ALUOp[0]; end
          3'b110:  begin dec_op = OP_OR;  dec_ill = io.Funct7b5 && !io.ALUOp[0]; end
          3'b010:  begin dec_op = OP_SLT; dec_ill = io.Funct7b5 && !io.ALUOp[0]; end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
    if (dec_ill) begin
      dec_op = OP_ADD;
      dec_br = BR_NONE;
    end
  end

  assign io.ReqReady = (state_q == IDLE) || (state_q == RESP && io.RespReady);
  assign req_fire    = io.ReqValid && io.ReqReady;
  assign resp_fire   = io.RespValid && io.RespReady;

  always_comb begin
    unique case (br_q)
      BR_EQ:   taken = AluZero;
      BR_NE:   taken = !AluZero;
      BR_LT:   taken = AluResult[0];
      BR_GE:   taken = !AluResult[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (io.RespReady) state_d = req_fire ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      br_q            <= BR_NONE;
      ill_q           <= 1'b0;
      ovf_en_q        <= 1'b0;
      AluA            <= '0;
      AluB            <= '0;
      AluOperation    <= OP_AND;
      io.RespValid    <= 1'b0;
      io.RespData     <= '0;
      io.RespZero     <= 1'b0;
      io.RespOverflow <= 1'b0;
      io.BranchTaken  <= 1'b0;
      io.IllegalOp    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        AluA         <= io.OpA;
        AluB         <= io.OpB;
        AluOperation <= dec_op;
        br_q         <= dec_br;
        ill_q        <= dec_ill;
        ovf_en_q     <= (dec_op == OP_ADD) || (dec_op == OP_SUB);
      end
      if (state_q == EXEC) begin
        io.RespValid    <= 1'b1;
        io.RespData     <= AluResult;
        io.RespZero     <= AluZero;
        io.RespOverflow <= AluOverflow && ovf_en_q;
        io.BranchTaken  <= taken;
        io.IllegalOp    <= ill_q;
      end else if (resp_fire) begin
        io.RespValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed table, hand-written backpressure/reset
// sequences and random transactions against a behavioural reference model.
module tb_alu_issue_ctrl;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] AluA, AluB, AluResult;
  logic [3:0]   AluOperation;
  logic         AluZero, AluOverflow;

  alu_issue_if #(.WIDTH(W)) ifc ();

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .io(ifc.slave),
    .AluA(AluA), .AluB(AluB), .AluOperation(AluOperation),
    .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow)
  );

  always #5 clk = ~clk;

  // Stand-in ALU. Overflow is left raw for logic ops so qualification is visible.
  logic [W-1:0] sum_w, dif_w;
  logic         add_v, sub_v;
  always_comb begin
    sum_w = AluA + AluB;
    dif_w = AluA - AluB;
    add_v = (AluA[W-1] == AluB[W-1]) && (sum_w[W-1] != AluA[W-1]);
    sub_v = (AluA[W-1] != AluB[W-1]) && (dif_w[W-1] != AluA[W-1]);
    AluResult   = '0;
    AluOverflow = add_v;
    case (AluOperation)
      4'b0000: AluResult = AluA & AluB;
      4'b0001: AluResult = AluA | AluB;
      4'b0010: AluResult = sum_w;
      4'b0110: begin AluResult = dif_w; AluOverflow = sub_v; end
      4'b0111: begin AluResult = {{(W-1){1'b0}}, ($signed(AluA) < $signed(AluB))}; AluOverflow = sub_v; end
      default: AluResult = '0;
    endcase
    AluZero = (AluResult == '0);
  end

  typedef struct {
    logic [1:0]   aluop;
    logic [2:0]   f3;
    logic         f7;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic [W-1:0] data;
    logic         zero, ovf, taken, ill;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: instruction semantics straight from the ISA meaning.
  function automatic vec_t model(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t r;
    logic [W:0] ext;
    logic lt;
    lt = $signed(a) < $signed(b);
    r = '{aluop, f3, f7, a, b, 4'b0010, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (aluop == 2'b01) begin
      case (f3)
        3'b000: begin r.op = 4'b0110; r.taken = (a == b); end
        3'b001: begin r.op = 4'b0110; r.taken = (a != b); end
        3'b100: begin r.op = 4'b0111; r.taken = lt; end
        3'b101: begin r.op = 4'b0111; r.taken = !lt; end
        default: r.ill = 1'b1;
      endcase
    end else if (aluop != 2'b00) begin
      case (f3)
        3'b000: r.op = (f7 && aluop == 2'b10) ? 4'b0110 : 4'b0010;
        3'b111: r.op = 4'b0000;
        3'b110: r.op = 4'b0001;
        3'b010: r.op = 4'b0111;
        default: r.ill = 1'b1;
      endcase
      if (f3 != 3'b000 && f7 && aluop == 2'b10) r.ill = 1'b1;
    end
    if (r.ill) r.op = 4'b0010;
    case (r.op)
      4'b0000: r.data = a & b;
      4'b0001: r.data = a | b;
      4'b0111: r.data = W'(lt);
      4'b0110: begin
        ext = {a[W-1], a} - {b[W-1], b};
        r.data = ext[W-1:0]; r.ovf = ext[W] != ext[W-1];
      end
      default: begin
        ext = {a[W-1], a} + {b[W-1], b};
        r.data = ext[W-1:0]; r.ovf = ext[W] != ext[W-1];
      end
    endcase
    r.zero = (r.data == '0);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    ifc.ReqValid = 1'b1;
    ifc.ALUOp    = v.aluop;
    ifc.Funct3   = v.f3;
    ifc.Funct7b5 = v.f7;
    ifc.OpA      = v.a;
    ifc.OpB      = v.b;
  endtask

  // Called at a negedge with inputs settled; returns once the request is accepted.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.ReqReady) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic check_resp(input string tag, input vec_t v);
    chk({tag, ".RespValid"}, ifc.RespValid, 1);
    chk({tag, ".RespData"}, ifc.RespData, v.data);
    chk({tag, ".RespZero"}, ifc.RespZero, v.zero);
    chk({tag, ".RespOverflow"}, ifc.RespOverflow, v.ovf);
    chk({tag, ".BranchTaken"}, ifc.BranchTaken, v.taken);
    chk({tag, ".IllegalOp"}, ifc.IllegalOp, v.ill);
  endtask

  // One transaction; the response is held for 'delay' cycles before being taken.
  task automatic run(input string tag, input vec_t v, input int delay);
    bit ok;
    @(negedge clk);
    drive(v);
    ifc.RespReady = (delay == 0);
    #1;
    wait_accept(ok);
    if (!ok) begin ifc.ReqValid = 1'b0; return; end
    @(negedge clk);
    ifc.ReqValid = 1'b0;
    chk({tag, ".AluOperation"}, AluOperation, v.op);
    chk({tag, ".AluA"}, AluA, v.a);
    chk({tag, ".AluB"}, AluB, v.b);
    chk({tag, ".exec_RespValid"}, ifc.RespValid, 0);
    @(negedge clk);
    check_resp(tag, v);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); #1;
      chk({tag, ".hold_RespValid"}, ifc.RespValid, 1);
      chk({tag, ".hold_RespData"}, ifc.RespData, v.data);
      chk({tag, ".hold_ReqReady"}, ifc.ReqReady, 0);
    end
    ifc.RespReady = 1'b1;
    @(negedge clk);
    chk({tag, ".after_RespValid"}, ifc.RespValid, 0);
  endtask

  vec_t tbl[15];
  vec_t va, vb;
  localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    bit ok;
    //         aluop  f3     f7 a        b        op       data   z  o  t  i
    tbl[0]  = '{2'b10, 3'b000, 0, 64'd5,   64'd7,   4'b0010, 64'd12, 0, 0, 0, 0};
    tbl[1]  = '{2'b01, 3'b000, 0, 64'h1234,64'h1234,4'b0110, 64'd0,  1, 0, 1, 0};
    tbl[2]  = '{2'b01, 3'b001, 0, 64'h1234,64'h1234,4'b0110, 64'd0,  1, 0, 0, 0};
    tbl[3]  = '{2'b01, 3'b100, 0, ALL1,    64'd1,   4'b0111, 64'd1,  0, 0, 1, 0};
    tbl[4]  = '{2'b01, 3'b101, 0, ALL1,    64'd1,   4'b0111, 64'd1,  0, 0, 0, 0};
    tbl[5]  = '{2'b10, 3'b000, 1, MINV,    64'd1,   4'b0110, MAXV,   0, 1, 0, 0};
    tbl[6]  = '{2'b11, 3'b000, 1, 64'd10,  64'd3,   4'b0010, 64'd13, 0, 0, 0, 0};
    tbl[7]  = '{2'b10, 3'b111, 0, 64'hF0,  64'h3C,  4'b0000, 64'h30, 0, 0, 0, 0};
    tbl[8]  = '{2'b10, 3'b110, 0, 64'hF0,  64'h0F,  4'b0001, 64'hFF, 0, 0, 0, 0};
    tbl[9]  = '{2'b11, 3'b010, 1, 64'd3,   64'd5,   4'b0111, 64'd1,  0, 0, 0, 0};
    tbl[10] = '{2'b10, 3'b111, 1, 64'd2,   64'd3,   4'b0010, 64'd5,  0, 0, 0, 1};
    tbl[11] = '{2'b01, 3'b010, 0, 64'd1,   64'd1,   4'b0010, 64'd2,  0, 0, 0, 1};
    tbl[12] = '{2'b00, 3'b011, 0, MAXV,    64'd1,   4'b0010, MINV,   0, 1, 0, 0};
    tbl[13] = '{2'b10, 3'b111, 0, MAXV,    64'd1,   4'b0000, 64'd1,  0, 0, 0, 0};
    tbl[14] = '{2'b10, 3'b010, 0, MINV,    64'd1,   4'b0111, 64'd1,  0, 0, 0, 0};

    ifc.ReqValid = 1'b0; ifc.ALUOp = '0; ifc.Funct3 = '0; ifc.Funct7b5 = 1'b0;
    ifc.OpA = '0; ifc.OpB = '0; ifc.RespReady = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.RespValid", ifc.RespValid, 0);
    chk("rst.AluOperation", AluOperation, 0);
    chk("rst.RespData", ifc.RespData, 0);
    chk("rst.AluA", AluA, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ReqReady", ifc.ReqReady, 1);

    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i], 0);

    // Backpressure: hold 5 cycles, then hand over to a new request in the same cycle.
    va = model(2'b10, 3'b000, 1'b0, 64'd100, 64'd23);
    vb = model(2'b10, 3'b110, 1'b0, 64'h0F00, 64'h00F0);
    @(negedge clk);
    drive(va); ifc.RespReady = 1'b0; #1;
    wait_accept(ok);
    @(negedge clk); ifc.ReqValid = 1'b0;
    @(negedge clk);
    check_resp("bp.a", va);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp.hold_RespValid", ifc.RespValid, 1);
      chk("bp.hold_RespData", ifc.RespData, va.data);
      chk("bp.hold_ReqReady", ifc.ReqReady, 0);
    end
    drive(vb); ifc.RespReady = 1'b1; #1;
    chk("bp.same_cycle_ReqReady", ifc.ReqReady, 1);
    @(negedge clk); ifc.ReqValid = 1'b0;
    chk("bp.b_exec_RespValid", ifc.RespValid, 0);
    chk("bp.b_AluOperation", AluOperation, vb.op);
    @(negedge clk);
    check_resp("bp.b", vb);
    @(negedge clk);
    chk("bp.b_done", ifc.RespValid, 0);

    // Reset in EXEC drops the in-flight op.
    va = model(2'b10, 3'b000, 1'b0, 64'd1, 64'd2);
    @(negedge clk);
    drive(va); ifc.RespReady = 1'b1; #1;
    wait_accept(ok);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rstx.RespValid", ifc.RespValid, 0);
    chk("rstx.AluOperation", AluOperation, 0);
    ifc.ReqValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rstx.ReqReady", ifc.ReqReady, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstx.no_stale", ifc.RespValid, 0);
    end

    // Random transactions against the model.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] op2; logic [2:0] f3; logic f7; logic [W-1:0] a, b;
      op2 = 2'($urandom); f3 = 3'($urandom); f7 = 1'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); end
        default: b = {$urandom, $urandom};
      endcase
      run($sformatf("rnd%0d", n), model(op2, f3, f7, a, b), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator for the 64-bit ALU datapath block. It accepts decoded instruction fields and operands over a valid/ready request channel, then generates the 4-bit ALU Operation code. It drives the registered operands into the combinational ALU, captures Result/Zero/Overflow one cycle later, and returns them with a branch decision over a valid/ready response channel. It sits between the decode stage and writeback/branch logic of the RISC-V datapath.

Parameters:
WIDTH, 64, operand/result width; must match the ALU width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ReqValid  in  1  request valid
ReqReady  out  1  request accepted when ReqValid&ReqReady at clk edge
ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
Funct3  in  3  instruction funct3
Funct7b5  in  1  instruction bit 30
OpA  in  WIDTH  first operand
OpB  in  WIDTH  second operand (register or immediate)
AluA  out  WIDTH  registered operand to ALU A
AluB  out  WIDTH  registered operand to ALU B
AluOperation  out  4  {Ainvert,Binvert/CarryIn,Sel[1:0]} to ALU
AluResult  in  WIDTH  ALU Result
AluZero  in  1  ALU Zero
AluOverflow  in  1  ALU Overflow
RespValid  out  1  response valid
RespReady  in  1  response accepted when RespValid&RespReady at clk edge
RespData  out  WIDTH  captured result
RespZero  out  1  captured Zero
RespOverflow  out  1  captured Overflow, qualified
BranchTaken  out  1  branch decision, 0 for non-branch
IllegalOp  out  1  decode error flag

Behaviour:
- Reset is asynchronous and active-low: all outputs 0, state IDLE, AluOperation=0000.
- Operation codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- Decode for ALUOp=00: ADD.
- Decode for ALUOp=01 (branches):
  - BEQ, Funct3 000: SUB, taken=Zero.
  - BNE, Funct3 001: SUB, taken=~Zero.
  - BLT, Funct3 100: SLT, taken=Result[0].
  - BGE, Funct3 101: SLT, taken=~Result[0].
  - Any other Funct3: illegal.
- Decode for ALUOp=10 (R-type):
  - Funct3 000: ADD if Funct7b5=0, SUB if 1.
  - Funct3 111: AND. Funct3 110: OR. Funct3 010: SLT.
  - For 111/110/010, Funct7b5=1 is illegal. Any other Funct3 is illegal.
- Decode for ALUOp=11 (I-type): same as 10, except Funct3 000 is always ADD (Funct7b5 ignored) and Funct7b5 never causes illegal.
- Illegal decode: AluOperation=ADD, operation still executes, IllegalOp=1 and BranchTaken=0 in the response.
- FSM states: IDLE, EXEC, RESP.
  - ReqReady = (state==IDLE) | (state==RESP & RespReady). This is combinational from RespReady.
  - Request handshake: register OpA→AluA, OpB→AluB, decoded code→AluOperation, latch the branch kind and illegal flag, go EXEC.
  - EXEC: one cycle. At the clock edge capture AluResult/AluZero/AluOverflow/BranchTaken/IllegalOp into the response registers, set RespValid=1, go RESP.
  - RESP: RespValid and all Resp* outputs are held stable until RespReady.
  - On response handshake, go EXEC if a request is accepted in the same cycle, else go IDLE and clear RespValid.
- Latency: a request accepted in cycle 0 gives RespValid=1 in cycle 2. Maximum throughput is one result per 2 cycles.
- RespOverflow = AluOverflow only for ADD/SUB; forced 0 for AND/OR/SLT.
- RespZero is passed through for all operations.
- AluA/AluB/AluOperation hold their last values outside EXEC; the ALU output is only sampled at the end of EXEC.
- Reset asserted in any state: state IDLE immediately, in-flight request and pending response discarded, RespValid=0.
- No request is lost: ReqReady is never high while an unconsumed response is held.

Test Plan:
- R-type ADD, OpA=5, OpB=7 → AluOperation=0010 in cycle 1; RespValid in cycle 2 with RespData=12, RespZero=0, BranchTaken=0.
- BEQ with OpA=OpB=0x1234 → AluOperation=0110, RespZero=1, BranchTaken=1; BNE with the same operands → BranchTaken=0.
- BLT with OpA=-1, OpB=1 → AluOperation=0111, RespData=1, BranchTaken=1; BGE with the same operands → BranchTaken=0, RespOverflow=0.
- R-type SUB, OpA=0x8000_0000_0000_0000, OpB=1 → RespData=0x7FFF_FFFF_FFFF_FFFF, RespOverflow=1.
- Backpressure:
  - Hold RespReady=0 for 5 cycles → RespValid=1, Resp* stable, ReqReady=0.
  - Then RespReady=1 with ReqValid=1 → new request accepted in that same cycle, and its response is valid 2 cycles later.
- ALUOp=10, Funct3=001 → IllegalOp=1, ADD result returned. Then assert rst_n=0 during EXEC → RespValid=0 at once, ReqReady=1 after release, and no stale response appears.
